// File: rtl/spi_send_fifo.sv
// SPI-slave transmit engine: AXI4-Stream words are buffered in a FIFO and
// shifted out on MISO under control of an external master. spi_clk and
// spi_cs are oversampled in the axi_aclk domain.
module spi_send_fifo #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    FIFO_DEPTH = 16,
    parameter bit                    CPOL       = 1'b0,
    parameter bit                    CPHA       = 1'b0,
    parameter bit                    MSB_FIRST  = 1'b1,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = '1
) (
    input  logic                            axi_aclk,
    input  logic                            axi_areset,
    input  logic                            spi_clk,
    input  logic                            spi_cs,
    output logic                            spi_miso,
    output logic                            spi_miso_oe,
    input  logic                            axis_rvalid,
    output logic                            axis_rready,
    input  logic [DATA_WIDTH-1:0]           axis_rdata,
    input  logic                            axis_rlast,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            underrun,
    output logic                            frame_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Synchroniser and history flops
    logic sclk_s1_q, sclk_s2_q, sclk_h_q;
    logic cs_s1_q, cs_s2_q, cs_h_q;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 rready_q, rready_d;

    // Transmit engine
    state_t               state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                 last_q, last_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 miso_q, miso_d;
    logic                 underrun_q, underrun_d;
    logic                 frame_done_q, frame_done_d;

    logic                 lead_edge_s, trail_edge_s, shift_edge_s;
    logic                 cs_fall_s, cs_rise_s;
    logic                 load_s, shift_s, push_s, pop_s, fifo_empty_s;
    logic [DATA_WIDTH:0]  head_s;

    // Two-flop synchronisers plus a history flop for edge detection
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            sclk_s1_q <= CPOL;
            sclk_s2_q <= CPOL;
            sclk_h_q  <= CPOL;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_h_q    <= 1'b1;
        end else begin
            sclk_s1_q <= spi_clk;
            sclk_s2_q <= sclk_s1_q;
            sclk_h_q  <= sclk_s2_q;
            cs_s1_q   <= spi_cs;
            cs_s2_q   <= cs_s1_q;
            cs_h_q    <= cs_s2_q;
        end
    end

    assign lead_edge_s  = (sclk_h_q == CPOL) && (sclk_s2_q != CPOL);
    assign trail_edge_s = (sclk_h_q != CPOL) && (sclk_s2_q == CPOL);
    assign shift_edge_s = CPHA ? lead_edge_s : trail_edge_s;
    assign cs_fall_s    = cs_h_q && !cs_s2_q;
    assign cs_rise_s    = !cs_h_q && cs_s2_q;

    assign fifo_empty_s = (level_q == {LVL_W{1'b0}});
    assign head_s       = mem_q[rd_ptr_q];
    assign push_s       = axis_rvalid && rready_q;
    assign pop_s        = load_s && !fifo_empty_s;

    // FIFO data array; contents need no reset because pointers define validity
    always_ff @(posedge axi_aclk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {axis_rlast, axis_rdata};
        end
    end

    // FIFO pointer, occupancy and ready next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        rready_d = (level_d != LVL_FULL);
    end

    // FIFO state registers
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rready_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rready_q <= rready_d;
        end
    end

    // Transmit FSM next-state: CS events take priority over clock edges
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        last_d       = last_q;
        bit_cnt_d    = bit_cnt_q;
        miso_d       = miso_q;
        underrun_d   = 1'b0;
        frame_done_d = 1'b0;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    load_s    = !CPHA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise_s) begin
                    // Abort: the partially sent word is dropped, never re-fetched
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    last_d    = 1'b0;
                end else if (shift_edge_s) begin
                    if (CPHA) begin
                        // Leading-edge launch: the first bit goes out with the load
                        load_s  = (bit_cnt_q == '0);
                        shift_s = (bit_cnt_q != '0);
                    end else begin
                        // Trailing-edge launch: next word is loaded at the wrap
                        load_s  = (bit_cnt_q == CNT_LAST);
                        shift_s = (bit_cnt_q != CNT_LAST);
                    end
                    if (bit_cnt_q == CNT_LAST) begin
                        bit_cnt_d    = '0;
                        frame_done_d = last_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        if (load_s) begin
            if (fifo_empty_s) begin
                shreg_d    = IDLE_WORD;
                last_d     = 1'b0;
                underrun_d = 1'b1;
            end else begin
                shreg_d = head_s[DATA_WIDTH-1:0];
                last_d  = head_s[DATA_WIDTH];
            end
            miso_d = MSB_FIRST ? shreg_d[DATA_WIDTH-1] : shreg_d[0];
        end else if (shift_s) begin
            shreg_d = MSB_FIRST ? {shreg_q[DATA_WIDTH-2:0], 1'b0}
                                : {1'b0, shreg_q[DATA_WIDTH-1:1]};
            miso_d  = MSB_FIRST ? shreg_d[DATA_WIDTH-1] : shreg_d[0];
        end else begin
            miso_d = miso_q;
        end
    end

    // Transmit FSM and shifter registers
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            last_q       <= 1'b0;
            bit_cnt_q    <= '0;
            miso_q       <= 1'b0;
            underrun_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            last_q       <= last_d;
            bit_cnt_q    <= bit_cnt_d;
            miso_q       <= miso_d;
            underrun_q   <= underrun_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = (state_q == ST_ACTIVE);
    assign axis_rready = rready_q;
    assign fifo_level  = level_q;
    assign underrun    = underrun_q;
    assign frame_done  = frame_done_q;

endmodule
